// File: rtl/ara_pkg.sv
// Shared types for the lane-level operand requesters: queue commands, target units,
// and the permutation requester's state encoding.
package ara_pkg;

    localparam int unsigned MaxVLEN = 65536;

    typedef logic [$clog2(MaxVLEN+1)-1:0] vlen_t;

    typedef enum logic [1:0] {
        ALU_SLDU     = 2'd0,
        MFPU_ADDRGEN = 2'd1
    } target_fu_e;

    typedef enum logic [3:0] {
        OpQueueConversionNone   = 4'd0,
        OpQueueConversionZExt2  = 4'd1,
        OpQueueConversionSExt2  = 4'd2,
        OpQueueConversionWideFP2 = 4'd3
    } opqueue_conversion_e;

    typedef struct packed {
        opqueue_conversion_e conv;
        vlen_t               elem_count;
        target_fu_e          target_fu;
    } operand_queue_cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } permu_req_state_e;

    // Rows occupied by one vector register in one lane; at least one.
    function automatic int unsigned rows_per_vreg(input int unsigned vlen,
                                                  input int unsigned lanes,
                                                  input int unsigned banks);
        int unsigned den;
        den = lanes * 64 * banks;
        if (den == 0 || vlen < den) return 1;
        return vlen / den;
    endfunction

endpackage

// File: rtl/permu_operand_requester.sv
// Permutation operand requester: pushes one queue command per request and issues
// full-row VRF reads under queue credit. Optional macro: PERMU_REQ_STALL_CNT_EN.
module permu_operand_requester
    import ara_pkg::*;
#(
    parameter int unsigned NrLanes           = 0,
    parameter int unsigned NrVRFBanksPerLane = 8,
    parameter int unsigned VLEN              = 0,
    parameter type operand_queue_cmd_t       = ara_pkg::operand_queue_cmd_t,
    parameter int unsigned RowsPerVReg       = rows_per_vreg(VLEN, NrLanes, NrVRFBanksPerLane),
    parameter int unsigned AddrWidth         = $clog2(32 * RowsPerVReg)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [4:0]           req_vs_i,
    input  vlen_t                req_rows_i,
    input  target_fu_e           req_target_fu_i,
    output operand_queue_cmd_t   opq_cmd_o,
    output logic                 opq_cmd_valid_o,
    input  logic                 opq_ready_i,
    input  logic                 opq_cmd_pop_i,
    output logic                 vrf_req_o,
    input  logic                 vrf_gnt_i,
    output logic [AddrWidth-1:0] vrf_addr_o,
    output logic                 operand_issued_o,
    output logic                 done_o,
    output logic                 busy_o
`ifdef PERMU_REQ_STALL_CNT_EN
    ,
    output logic [31:0]          stall_cycles_o
`endif
);

    localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(32 * RowsPerVReg - 1);

    permu_req_state_e      r_state, w_state_d;
    logic [4:0]            r_vs;
    vlen_t                 r_rows;
    vlen_t                 r_row_cnt;
    target_fu_e            r_target_fu;
    logic [AddrWidth-1:0]  r_addr;
    logic                  r_cmd_valid;
    logic                  r_done;
    logic                  r_pop_seen;

    logic                  w_accept;
    logic                  w_rows_nz;
    logic                  w_gnt;
    logic                  w_last_gnt;
    logic                  w_pop_early;
    logic                  w_done_d;
    logic [AddrWidth-1:0]  w_base;

    assign w_accept    = (r_state == IDLE) && req_valid_i && !flush_i;
    assign w_rows_nz   = (req_rows_i != '0);
    assign vrf_req_o   = (r_state == ISSUE) && opq_ready_i && !flush_i;
    assign w_gnt       = vrf_req_o && vrf_gnt_i;
    assign w_last_gnt  = w_gnt && (r_row_cnt == r_rows - vlen_t'(1));
    // A pop seen in the same cycle as the last grant counts as early as well.
    assign w_pop_early = r_pop_seen || opq_cmd_pop_i;
    assign w_base      = AddrWidth'(req_vs_i) * AddrWidth'(RowsPerVReg);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_done_d  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_rows_nz) w_state_d = ISSUE;
                    else           w_done_d  = 1'b1;
                end
            end
            ISSUE: begin
                if (w_last_gnt) begin
                    if (w_pop_early) begin
                        w_state_d = IDLE;
                        w_done_d  = 1'b1;
                    end else begin
                        w_state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (opq_cmd_pop_i) begin
                    w_state_d = IDLE;
                    w_done_d  = 1'b1;
                end
            end
            default: w_state_d = IDLE;
        endcase
        if (flush_i) begin
            w_state_d = IDLE;
            w_done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_vs        <= '0;
            r_rows      <= '0;
            r_target_fu <= ALU_SLDU;
            r_row_cnt   <= '0;
            r_addr      <= '0;
            r_cmd_valid <= 1'b0;
            r_done      <= 1'b0;
            r_pop_seen  <= 1'b0;
        end else begin
            r_cmd_valid <= w_accept && w_rows_nz;
            r_done      <= w_done_d;
            if (flush_i) begin
                r_row_cnt  <= '0;
                r_pop_seen <= 1'b0;
            end else if (w_accept) begin
                r_vs        <= req_vs_i;
                r_rows      <= req_rows_i;
                r_target_fu <= req_target_fu_i;
                r_row_cnt   <= '0;
                r_addr      <= w_base;
                r_pop_seen  <= 1'b0;
            end else begin
                if (w_gnt) begin
                    r_row_cnt <= r_row_cnt + vlen_t'(1);
                    r_addr    <= (r_addr == LastAddr) ? '0 : r_addr + AddrWidth'(1);
                end
                if (r_state == ISSUE && opq_cmd_pop_i) r_pop_seen <= 1'b1;
            end
        end
    end

`ifdef PERMU_REQ_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    // Saturating; survives flush so software can still read the aborted run.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stall_cnt <= '0;
        end else if (w_accept) begin
            r_stall_cnt <= '0;
        end else if (r_state == ISSUE && !w_gnt && r_stall_cnt != '1) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cycles_o = r_stall_cnt;
`endif

    always_comb begin
        opq_cmd_o            = '0;
        opq_cmd_o.elem_count = r_rows - vlen_t'(1);
        opq_cmd_o.conv       = OpQueueConversionNone;
        opq_cmd_o.target_fu  = r_target_fu;
    end

    assign opq_cmd_valid_o  = r_cmd_valid && !flush_i;
    assign req_ready_o      = (r_state == IDLE) && !flush_i;
    assign vrf_addr_o       = r_addr;
    assign operand_issued_o = w_gnt;
    assign done_o           = r_done;
    assign busy_o           = (r_state != IDLE);

    logic w_unused;
    assign w_unused = ^r_vs;

endmodule

// File: tb/tb_permu_operand_requester.sv
// Directed bench for permu_operand_requester with RowsPerVReg=2 (6-bit row address).
module tb_permu_operand_requester;
    import ara_pkg::*;

    logic               clk_i = 1'b0;
    logic               rst_ni = 1'b0;
    logic               flush_i = 1'b0;
    logic               req_valid_i = 1'b0;
    logic               req_ready_o;
    logic [4:0]         req_vs_i = '0;
    vlen_t              req_rows_i = '0;
    target_fu_e         req_target_fu_i = ALU_SLDU;
    operand_queue_cmd_t opq_cmd_o;
    logic               opq_cmd_valid_o;
    logic               opq_ready_i = 1'b0;
    logic               opq_cmd_pop_i = 1'b0;
    logic               vrf_req_o;
    logic               vrf_gnt_i = 1'b0;
    logic [5:0]         vrf_addr_o;
    logic               operand_issued_o;
    logic               done_o;
    logic               busy_o;
`ifdef PERMU_REQ_STALL_CNT_EN
    logic [31:0]        stall_cycles_o;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int n_issued = 0;

    permu_operand_requester #(
        .NrLanes(1),
        .NrVRFBanksPerLane(8),
        .VLEN(1024)
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .flush_i(flush_i),
        .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o),
        .req_vs_i(req_vs_i),
        .req_rows_i(req_rows_i),
        .req_target_fu_i(req_target_fu_i),
        .opq_cmd_o(opq_cmd_o),
        .opq_cmd_valid_o(opq_cmd_valid_o),
        .opq_ready_i(opq_ready_i),
        .opq_cmd_pop_i(opq_cmd_pop_i),
        .vrf_req_o(vrf_req_o),
        .vrf_gnt_i(vrf_gnt_i),
        .vrf_addr_o(vrf_addr_o),
        .operand_issued_o(operand_issued_o),
        .done_o(done_o),
        .busy_o(busy_o)
`ifdef PERMU_REQ_STALL_CNT_EN
        ,
        .stall_cycles_o(stall_cycles_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic send(input logic [4:0] vs, input int rows, input target_fu_e fu);
        req_valid_i     = 1'b1;
        req_vs_i        = vs;
        req_rows_i      = vlen_t'(rows);
        req_target_fu_i = fu;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        check_val("rst_req_ready", req_ready_o, 1);
        check_val("rst_busy", busy_o, 0);
        check_val("rst_done", done_o, 0);
        check_val("rst_cmd_valid", opq_cmd_valid_o, 0);
        check_val("rst_vrf_req", vrf_req_o, 0);
        check_val("rst_addr", vrf_addr_o, 0);
        rst_ni = 1'b1;
        tick;

        // T1: vs=3 rows=4, no stalls, pop in DRAIN
        opq_ready_i = 1'b1;
        vrf_gnt_i   = 1'b1;
        send(5'd3, 4, MFPU_ADDRGEN);
        settle;
        check_val("t1_ready_c0", req_ready_o, 1);
        tick;
        req_valid_i = 1'b0;
        settle;
        check_val("t1_cmd_valid_c1", opq_cmd_valid_o, 1);
        check_val("t1_elem_count", opq_cmd_o.elem_count, 3);
        check_val("t1_target_fu", opq_cmd_o.target_fu, MFPU_ADDRGEN);
        check_val("t1_conv", opq_cmd_o.conv, OpQueueConversionNone);
        check_val("t1_vrf_req_c1", vrf_req_o, 1);
        check_val("t1_addr_c1", vrf_addr_o, 6);
        check_val("t1_busy_c1", busy_o, 1);
        for (int i = 1; i < 4; i++) begin
            tick;
            settle;
            check_val("t1_addr", vrf_addr_o, 32'(6 + i));
        end
        check_val("t1_cmd_valid_c4", opq_cmd_valid_o, 0);
        tick;
        settle;
        check_val("t1_vrf_req_drain", vrf_req_o, 0);
        check_val("t1_busy_drain", busy_o, 1);
        tick;
        tick;
        opq_cmd_pop_i = 1'b1;
        settle;
        check_val("t1_done_c7", done_o, 0);
        tick;
        opq_cmd_pop_i = 1'b0;
        settle;
        check_val("t1_done_c8", done_o, 1);
        check_val("t1_busy_c8", busy_o, 0);
        check_val("t1_ready_c8", req_ready_o, 1);
        tick;
        settle;
        check_val("t1_done_c9", done_o, 0);

        // T2: rows=0 completes without command or reads
        send(5'd5, 0, ALU_SLDU);
        tick;
        req_valid_i = 1'b0;
        settle;
        check_val("t2_done", done_o, 1);
        check_val("t2_cmd_valid", opq_cmd_valid_o, 0);
        check_val("t2_vrf_req", vrf_req_o, 0);
        check_val("t2_ready", req_ready_o, 1);
        check_val("t2_busy", busy_o, 0);
        tick;
        settle;
        check_val("t2_done_once", done_o, 0);

        // T3: vs=31 wraps to row 0
        send(5'd31, 3, ALU_SLDU);
        tick;
        req_valid_i = 1'b0;
        settle;
        check_val("t3_elem_count", opq_cmd_o.elem_count, 2);
        check_val("t3_addr0", vrf_addr_o, 62);
        tick;
        settle;
        check_val("t3_addr1", vrf_addr_o, 63);
        tick;
        settle;
        check_val("t3_addr2", vrf_addr_o, 0);
        tick;
        opq_cmd_pop_i = 1'b1;
        settle;
        check_val("t3_vrf_req_drain", vrf_req_o, 0);
        tick;
        opq_cmd_pop_i = 1'b0;
        settle;
        check_val("t3_done", done_o, 1);
        tick;

        // T4: credit stall cycles 2-4, early pop during stall
        n_issued = 0;
        send(5'd0, 3, ALU_SLDU);
        tick;
        req_valid_i = 1'b0;
        settle;
        n_issued += int'(operand_issued_o);
        check_val("t4_addr_c1", vrf_addr_o, 0);
        for (int c = 2; c <= 4; c++) begin
            tick;
            opq_ready_i   = 1'b0;
            opq_cmd_pop_i = (c == 2);
            settle;
            n_issued += int'(operand_issued_o);
            check_val("t4_vrf_req_stall", vrf_req_o, 0);
            check_val("t4_addr_hold", vrf_addr_o, 1);
        end
        tick;
        opq_cmd_pop_i = 1'b0;
        opq_ready_i   = 1'b1;
        settle;
        n_issued += int'(operand_issued_o);
        check_val("t4_addr_c5", vrf_addr_o, 1);
        tick;
        settle;
        n_issued += int'(operand_issued_o);
        check_val("t4_addr_c6", vrf_addr_o, 2);
        check_val("t4_done_c6", done_o, 0);
        tick;
        settle;
        n_issued += int'(operand_issued_o);
        check_val("t4_done_c7", done_o, 1);
        check_val("t4_busy_c7", busy_o, 0);
        check_val("t4_issued", n_issued, 3);
`ifdef PERMU_REQ_STALL_CNT_EN
        check_val("t4_stall", stall_cycles_o, 3);
`endif
        tick;

        // T5: flush mid-request, then a new request starts from row 0
        send(5'd2, 5, ALU_SLDU);
        tick;
        req_valid_i = 1'b0;
        settle;
        check_val("t5_addr_c1", vrf_addr_o, 4);
        tick;
        flush_i = 1'b1;
        settle;
        check_val("t5_ready_flush", req_ready_o, 0);
        check_val("t5_vrf_req_flush", vrf_req_o, 0);
        check_val("t5_cmd_valid_flush", opq_cmd_valid_o, 0);
        tick;
        flush_i = 1'b0;
        settle;
        check_val("t5_busy_c3", busy_o, 0);
        check_val("t5_done_c3", done_o, 0);
        check_val("t5_ready_c3", req_ready_o, 1);
        send(5'd1, 2, MFPU_ADDRGEN);
        tick;
        req_valid_i = 1'b0;
        settle;
        check_val("t5_new_cmd_valid", opq_cmd_valid_o, 1);
        check_val("t5_new_elem_count", opq_cmd_o.elem_count, 1);
        check_val("t5_new_addr0", vrf_addr_o, 2);
        tick;
        opq_cmd_pop_i = 1'b1;
        settle;
        check_val("t5_new_addr1", vrf_addr_o, 3);
        check_val("t5_done_last", done_o, 0);
        tick;
        opq_cmd_pop_i = 1'b0;
        settle;
        check_val("t5_done_early_pop", done_o, 1);
        check_val("t5_busy_end", busy_o, 0);
        tick;

        // T6: grant withheld two cycles, pop on the last row
        send(5'd4, 2, ALU_SLDU);
        tick;
        req_valid_i = 1'b0;
        vrf_gnt_i   = 1'b0;
        settle;
        check_val("t6_vrf_req_c1", vrf_req_o, 1);
        check_val("t6_issued_c1", operand_issued_o, 0);
        tick;
        settle;
        check_val("t6_addr_c2", vrf_addr_o, 8);
        tick;
        vrf_gnt_i = 1'b1;
        settle;
        check_val("t6_issued_c3", operand_issued_o, 1);
        check_val("t6_addr_c3", vrf_addr_o, 8);
        tick;
        opq_cmd_pop_i = 1'b1;
        settle;
        check_val("t6_addr_c4", vrf_addr_o, 9);
        tick;
        opq_cmd_pop_i = 1'b0;
        settle;
        check_val("t6_done", done_o, 1);
        check_val("t6_busy", busy_o, 0);
`ifdef PERMU_REQ_STALL_CNT_EN
        check_val("t6_stall", stall_cycles_o, 2);
`endif
        tick;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
